// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit arbiter slice.
//   UART_DATA_W       - byte width carried to the transmitter
//   UART_FRAME_CYCLES - clocks per frame (start + 8 data + stop)
//   uart_arb_state_e  - arbiter FSM states (IDLE=0, START=1, WAIT=2, GAP=3)
//   max_int()         - helper used to size the frame/gap counter
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_FRAME_CYCLES = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } uart_arb_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_req_arbiter.sv
// uart_req_arbiter: picks one requester out of NREQ valids.
//   clk, reset  - clock and synchronous active-low reset (round-robin pointer only)
//   valid_i     - per-requester request
//   update_i    - accept strobe; advances the round-robin pointer
//   grant_o     - one-hot grant (all zero when no request)
//   idx_o       - index of the granted requester
// Build option: UART_TX_ARB_RR_EN selects round-robin; otherwise fixed
// priority with the lowest index winning and no pointer state.
module uart_req_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] valid_i,
    input  logic            update_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o
);

`ifdef UART_TX_ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;
    int unsigned    j;

    always_ff @(posedge clk) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // Next search starts one past the requester just accepted.
    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = (idx_o == IDW'(NREQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    // Rotate the search origin to ptr_q; wrap manually so NREQ need not be a power of two.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && valid_i[j[IDW-1:0]]) begin
                found                = 1'b1;
                grant_o[j[IDW-1:0]]  = 1'b1;
                idx_o                = j[IDW-1:0];
            end
        end
    end
`else
    logic found;
    logic unused_rr;

    assign unused_rr = ^{clk, reset, update_i};

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && valid_i[i]) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART transmitter among NREQ requesters.
//   clk, reset - clock and synchronous active-low reset
//   req_valid  - per-requester byte valid
//   req_data   - requester i byte at [8*i+7:8*i]
//   req_ready  - one-hot accept, only in IDLE and only while out of reset
//   tx_data    - byte to the transmitter, held until the next accept
//   tx_start   - one-cycle start strobe to the transmitter
//   busy       - high from the accept until the FSM is back in IDLE
//   grant_id   - index of the requester owning the current frame
// Build option: UART_TX_ARB_RR_EN selects round-robin arbitration
// (default: fixed priority, lowest index wins).
// Frame completion is counter-timed; the transmitter's sticky done is not used.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ         = 4,
    parameter  int FRAME_CYCLES = UART_FRAME_CYCLES,
    parameter  int GAP_CYCLES   = 1,
    localparam int IDW          = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic [UART_DATA_W-1:0]      tx_data,
    output logic                        tx_start,
    output logic                        busy,
    output logic [IDW-1:0]              grant_id
);

    localparam int CNT_W = $clog2(max_int(FRAME_CYCLES, GAP_CYCLES) + 1);

    uart_arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [IDW-1:0]         grant_id_q, grant_id_d;
    logic                   busy_q, busy_d;

    logic [NREQ-1:0]        arb_grant;
    logic [IDW-1:0]         arb_idx;
    logic [UART_DATA_W-1:0] sel_data;
    logic                   accept;

    uart_req_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (req_valid),
        .update_i (accept),
        .grant_o  (arb_grant),
        .idx_o    (arb_idx)
    );

    // Ready is gated by reset so nothing is accepted while reset is low.
    assign req_ready = (state_q == ST_IDLE && reset) ? arb_grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == IDW'(i)) sel_data = req_data[UART_DATA_W*i +: UART_DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_data_d  = sel_data;
                    grant_id_d = arb_idx;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = CNT_W'(FRAME_CYCLES - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                        state_d = ST_GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_start = (state_q == ST_START);
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter (defaults, plus a
// GAP_CYCLES=0 instance). Expected bytes/ids queue up when requests are
// driven and are retired against each tx_start.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic [1:0]  grant_id;

    logic [3:0]  v0;
    logic [31:0] d0;
    logic [3:0]  ready0;
    logic [7:0]  tx_data0;
    logic        tx_start0;
    logic        busy0;
    logic [1:0]  grant_id0;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          n;
    int          w;
    int          last_acc;
    bit          mon_en = 1'b0;
    logic        prev_start  = 1'b0;
    logic        prev_start0 = 1'b0;
    logic [9:0]  sb[$];
    logic [9:0]  mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_tx_arbiter #(
        .NREQ         (4),
        .FRAME_CYCLES (10),
        .GAP_CYCLES   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    uart_tx_arbiter #(
        .NREQ         (4),
        .FRAME_CYCLES (10),
        .GAP_CYCLES   (0)
    ) dut_g0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (v0),
        .req_data  (d0),
        .req_ready (ready0),
        .tx_data   (tx_data0),
        .tx_start  (tx_start0),
        .busy      (busy0),
        .grant_id  (grant_id0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", {31'b0, k < budget}, 1);
    endtask

    // Per-cycle invariants and scoreboard retirement on each start strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("double_start", {31'b0, tx_start & prev_start}, 0);
            chk("ready_while_busy", {31'b0, (|req_ready) & busy}, 0);
            chk("g0_double_start", {31'b0, tx_start0 & prev_start0}, 0);
            chk("g0_ready_while_busy", {31'b0, (|ready0) & busy0}, 0);
            if (tx_start === 1'b1) begin
                chk("sb_underflow", {31'b0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    mon_exp = sb.pop_front();
                    chk("tx_data", {24'b0, tx_data}, {24'b0, mon_exp[7:0]});
                    chk("grant_id", {30'b0, grant_id}, {30'b0, mon_exp[9:8]});
                end
            end
            prev_start  = tx_start;
            prev_start0 = tx_start0;
        end
    end

    initial begin
        reset     = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hD3D2D1D0;
        v0        = 4'h0;
        d0        = 32'h0;

        // Reset with all requesters valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {28'b0, req_ready}, 0);
        chk("reset_start", {31'b0, tx_start}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_tx_data", {24'b0, tx_data}, 0);
        chk("reset_grant_id", {30'b0, grant_id}, 0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("release_ready", {28'b0, req_ready}, 32'h1);
        sb.push_back({2'd0, 8'hD0});
        @(posedge clk); #1;
        req_valid = 4'h0;
        @(negedge clk);
        chk("release_start", {31'b0, tx_start}, 1);
        wait_idle(40);

        // Single byte from requester 2
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        #1;
        chk("single_ready", {28'b0, req_ready}, 32'h4);
        sb.push_back({2'd2, 8'hA5});
        @(posedge clk); #1;
        req_valid = 4'h0;
        @(negedge clk);
        chk("single_start", {31'b0, tx_start}, 1);
        repeat (11) @(negedge clk);
        chk("busy_hold", {31'b0, busy}, 1);
        @(negedge clk);
        chk("busy_drop", {31'b0, busy}, 0);

        // Back-to-back from requester 1
        req_data[15:8] = 8'h11;
        req_valid      = 4'b0010;
        #1;
        chk("b2b_ready", {28'b0, req_ready}, 32'h2);
        sb.push_back({2'd1, 8'h11});
        @(posedge clk); #1;
        req_data[15:8] = 8'h22;
        sb.push_back({2'd1, 8'h22});
        @(negedge clk);
        chk("b2b_start1", {31'b0, tx_start}, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_start !== 1'b1 && n < 30);
        chk("b2b_period", n, 13);
        req_valid = 4'h0;
        wait_idle(40);

        // Contention from a fresh reset
        reset     = 1'b0;
        req_valid = 4'h0;
        repeat (2) @(posedge clk); #1;
        reset     = 1'b1;
        req_data  = 32'hC3C2C1C0;
        req_valid = 4'hF;
        #1;
        last_acc = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (req_ready === 4'h0 && n < 30) begin
                @(negedge clk);
                n++;
            end
`ifdef UART_TX_ARB_RR_EN
            w = k % 4;
`else
            w = 0;
`endif
            chk("arb_grant", {28'b0, req_ready}, 32'(1) << w);
            if (k > 0) chk("arb_spacing", cyc - last_acc, 13);
            last_acc = cyc;
            sb.push_back({w[1:0], 8'hC0 + w[7:0]});
            @(posedge clk); #1;
            if (k == 4) req_valid = 4'h0;
        end
        @(negedge clk);
        wait_idle(40);

        // Reset in the middle of a frame
        req_data[23:16] = 8'h5A;
        req_valid       = 4'b0100;
        #1;
        chk("mid_ready0", {28'b0, req_ready}, 32'h4);
        sb.push_back({2'd2, 8'h5A});
        @(posedge clk); #1;
        req_valid = 4'h0;
        @(negedge clk);
        chk("mid_start", {31'b0, tx_start}, 1);
        repeat (4) @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset          = 1'b1;
        req_data[15:8] = 8'h77;
        req_valid      = 4'b0010;
        #1;
        chk("mid_ready", {28'b0, req_ready}, 32'h2);
        chk("mid_busy", {31'b0, busy}, 0);
        chk("mid_no_start", {31'b0, tx_start}, 0);
        sb.push_back({2'd1, 8'h77});
        @(posedge clk); #1;
        req_valid = 4'h0;
        @(negedge clk);
        chk("mid_restart", {31'b0, tx_start}, 1);
        wait_idle(40);

        // Zero-gap instance: continuous requester 3
        d0[31:24] = 8'h3C;
        v0        = 4'b1000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_start0 !== 1'b1 && n < 30);
        chk("g0_first_start", {31'b0, tx_start0}, 1);
        chk("g0_tx_data", {24'b0, tx_data0}, 32'h3C);
        chk("g0_grant_id", {30'b0, grant_id0}, 3);
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (tx_start0 !== 1'b1 && n < 30);
            chk("g0_period", n, 12);
        end
        v0 = 4'h0;

        repeat (20) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
